// File: rtl/bnn_output_packer_pkg.sv
// Shared definitions for the binary-NN output packer, compute stage and input RAM.
// Optional popcount feature in the packer is enabled by defining BNN_PACK_POPCOUNT_EN.
package bnn_output_packer_pkg;

    localparam int unsigned DEF_I_ADDR_LEN = 10;
    localparam int unsigned DEF_I_DATA_LEN = 8;

    typedef enum logic [2:0] {
        StIdle,
        StPack,
        StWrite,
        StDrain,
        StDone
    } pack_state_e;

endpackage

// File: rtl/bnn_output_packer_bit_shifter.sv
// LSB-first shift register with bit counter; word_full marks the shift that fills the word.
module bnn_bit_shifter
    import bnn_output_packer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_I_DATA_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word,
    output logic             word_full
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en && (cnt_q < CNT_W'(WIDTH))) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    word_d[i] = bit_in;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word      = word_q;
    assign word_full = shift_en && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/bnn_output_packer.sv
// Packs sign-activation bits LSB-first into words and writes them to the next layer's RAM.
// Define BNN_PACK_POPCOUNT_EN to count accepted 1-bits on ones_count (otherwise tied to 0).
module bnn_output_packer
    import bnn_output_packer_pkg::*;
#(
    parameter int unsigned I_ADDR_LEN = DEF_I_ADDR_LEN,
    parameter int unsigned I_DATA_LEN = DEF_I_DATA_LEN,
    parameter int unsigned MAX_WORDS  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  act_valid,
    input  logic                  act_bit,
    input  logic                  act_last,
    output logic                  act_ready,
    input  logic                  ram_busy,
    output logic                  wr_en,
    output logic [I_ADDR_LEN-1:0] wr_addr,
    output logic [I_DATA_LEN-1:0] wr_data,
    output logic                  done,
    output logic [I_ADDR_LEN:0]   word_count,
    output logic                  overflow,
    output logic [I_ADDR_LEN+3:0] ones_count
);

    localparam logic [I_ADDR_LEN:0] MAX_CNT = (I_ADDR_LEN + 1)'(MAX_WORDS);

    pack_state_e state_q, state_d;

    logic [I_ADDR_LEN-1:0] addr_q, addr_d;
    logic [I_ADDR_LEN:0]   wcnt_q, wcnt_d;
    logic                  ovf_q, ovf_d;
    logic                  last_q, last_d;
    logic                  sh_clear, sh_shift, sh_full;

    bnn_bit_shifter #(
        .WIDTH (I_DATA_LEN)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .clear     (sh_clear),
        .shift_en  (sh_shift),
        .bit_in    (act_bit),
        .word      (wr_data),
        .word_full (sh_full)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wcnt_d    = wcnt_q;
        ovf_d     = ovf_q;
        last_d    = last_q;
        act_ready = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        sh_clear  = 1'b0;
        sh_shift  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Run statistics stay visible until the next start.
                sh_clear = 1'b1;
                if (start) begin
                    state_d = StPack;
                    addr_d  = '0;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                    last_d  = 1'b0;
                end
            end
            StPack: begin
                act_ready = 1'b1;
                if (act_valid) begin
                    sh_shift = 1'b1;
                    if (sh_full || act_last) begin
                        state_d = StWrite;
                        last_d  = act_last;
                    end
                end
            end
            StWrite: begin
                wr_en = ~ram_busy;
                if (!ram_busy) begin
                    addr_d   = addr_q + 1'b1;
                    wcnt_d   = wcnt_q + 1'b1;
                    sh_clear = 1'b1;
                    if (last_q) begin
                        state_d = StDone;
                    end else if (wcnt_d == MAX_CNT) begin
                        state_d = StDrain;
                    end else begin
                        state_d = StPack;
                    end
                end
            end
            StDrain: begin
                act_ready = 1'b1;
                if (act_valid) begin
                    ovf_d = 1'b1;
                    if (act_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
        end
    end

    assign wr_addr    = addr_q;
    assign word_count = wcnt_q;
    assign overflow   = ovf_q;

`ifdef BNN_PACK_POPCOUNT_EN
    logic [I_ADDR_LEN+3:0] ones_q;

    // Bits dropped in DRAIN are deliberately not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            ones_q <= '0;
        end else if ((state_q == StPack) && act_valid && act_bit) begin
            ones_q <= ones_q + 1'b1;
        end
    end

    assign ones_count = ones_q;
`else
    assign ones_count = '0;
`endif

endmodule

// File: tb/tb_bnn_output_packer.sv
// Directed bench for bnn_output_packer with a bit-stream model and per-cycle output checks.
module tb_bnn_output_packer;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned MW = 2;

    logic          clk = 1'b0;
    logic          rst, start, act_valid, act_bit, act_last, ram_busy;
    logic          act_ready, wr_en, done, overflow;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   word_count;
    logic [AW+3:0] ones_count;

    always #5 clk = ~clk;

    bnn_output_packer #(
        .I_ADDR_LEN (AW),
        .I_DATA_LEN (DW),
        .MAX_WORDS  (MW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .act_valid  (act_valid),
        .act_bit    (act_bit),
        .act_last   (act_last),
        .act_ready  (act_ready),
        .ram_busy   (ram_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .done       (done),
        .word_count (word_count),
        .overflow   (overflow),
        .ones_count (ones_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: a run is the stream of accepted bits; the first MW*DW bits form words, the rest drop.
    bit            in_run, write_due, done_due, last_word, m_ovf;
    int            nbits, words_sent, ones, stall_cycles, done_cnt;
    logic [DW-1:0] partial;
    logic [DW-1:0] exp_data_q[$];
    int            exp_addr_q[$];
    logic [DW-1:0] log_data[$];
    int            log_addr[$];

    always @(negedge clk) begin
        if (rst) begin
            check("rst_wr_en", wr_en, 0);
            check("rst_act_ready", act_ready, 0);
            check("rst_done", done, 0);
            check("rst_wr_addr", wr_addr, 0);
            check("rst_wr_data", wr_data, 0);
            check("rst_word_count", word_count, 0);
            check("rst_overflow", overflow, 0);
            check("rst_ones_count", ones_count, 0);
            in_run = 0; write_due = 0; done_due = 0; last_word = 0;
            exp_data_q.delete();
            exp_addr_q.delete();
        end else begin
            bit rdy, next_done;
            int exp_ones;
            rdy = in_run && !write_due && !done_due;
            check("wr_en", wr_en, write_due && !ram_busy);
            check("act_ready", act_ready, rdy);
            check("done", done, done_due);
            if (write_due && ram_busy) stall_cycles++;
            if (wr_en) begin
                log_data.push_back(wr_data);
                log_addr.push_back(int'(wr_addr));
                if (exp_data_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("wr_addr", wr_addr, exp_addr_q.pop_front());
                    check("wr_data", wr_data, exp_data_q.pop_front());
                end
            end
            if (done) begin
`ifdef BNN_PACK_POPCOUNT_EN
                exp_ones = ones;
`else
                exp_ones = 0;
`endif
                done_cnt++;
                check("done_word_count", word_count, words_sent);
                check("done_overflow", overflow, m_ovf);
                check("done_ones_count", ones_count, exp_ones);
                check("done_pending_writes", exp_data_q.size(), 0);
            end

            next_done = 0;
            if (write_due && !ram_busy) begin
                write_due = 0;
                words_sent++;
                if (last_word) next_done = 1;
            end
            if (done_due) begin
                in_run = 0;
            end else if (!in_run) begin
                if (start) begin
                    in_run = 1; nbits = 0; words_sent = 0; ones = 0; m_ovf = 0; partial = '0;
                end
            end else if (rdy && act_valid) begin
                if (nbits < int'(MW * DW)) begin
                    partial = partial | (DW'(act_bit) << (nbits % DW));
                    if (act_bit) ones++;
                    nbits++;
                    if ((nbits % DW == 0) || act_last) begin
                        exp_data_q.push_back(partial);
                        exp_addr_q.push_back((nbits - 1) / DW);
                        partial   = '0;
                        write_due = 1;
                        last_word = act_last;
                    end
                end else begin
                    m_ovf = 1;
                    if (act_last) next_done = 1;
                end
            end
            done_due = next_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic b, input logic l);
        bit ok = 0;
        act_valid = 1'b1; act_bit = b; act_last = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = act_ready;
            tick();
        end
        act_valid = 1'b0; act_bit = 1'b0; act_last = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input bit last_at_end);
        for (int i = 0; i < n; i++) begin
            send(((bits >> i) & 32'd1) != 0, last_at_end && (i == n - 1));
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 100 && done_cnt < target; i++) tick();
        if (done_cnt < target) check("done_timeout", done_cnt, target);
        repeat (3) tick();
        check("done_pulses", done_cnt, target);
    endtask

    task automatic clear_log();
        log_data.delete();
        log_addr.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; act_valid = 1'b0; act_bit = 1'b0;
        act_last = 1'b0; ram_busy = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1,0,1,1,0,0,0,0 then eight 1s; last word fills MAX_WORDS with last set.
        clear_log();
        do_start();
        send_bits(32'h0000_FF0D, 16, 1);
        wait_done(1);
        check("t1_writes", log_data.size(), 2);
        check("t1_data0", log_data[0], 8'h0D);
        check("t1_data1", log_data[1], 8'hFF);
        check("t1_addr1", log_addr[1], 1);
        check("t1_word_count", word_count, 2);
        check("t1_overflow", overflow, 0);

        // 11 ones: a full word and a zero-padded partial word.
        clear_log();
        do_start();
        send_bits(32'h0000_07FF, 11, 1);
        wait_done(2);
        check("t2_data0", log_data[0], 8'hFF);
        check("t2_data1", log_data[1], 8'h07);
        check("t2_word_count", word_count, 2);
`ifdef BNN_PACK_POPCOUNT_EN
        check("t2_ones", ones_count, 11);
`else
        check("t2_ones", ones_count, 0);
`endif

        // RAM busy for five cycles while the word waits.
        clear_log();
        stall_cycles = 0;
        ram_busy = 1'b1;
        do_start();
        send_bits(32'h0000_00A5, 8, 1);
        repeat (5) tick();
        ram_busy = 1'b0;
        wait_done(3);
        check("t3_stalls", stall_cycles, 5);
        check("t3_writes", log_data.size(), 1);
        check("t3_data0", log_data[0], 8'hA5);
        check("t3_addr0", log_addr[0], 0);

        // 24 bits into a 2-word run: third byte dropped.
        clear_log();
        do_start();
        send_bits(32'h00FF_3CA5, 24, 1);
        wait_done(4);
        check("t4_writes", log_data.size(), 2);
        check("t4_data0", log_data[0], 8'hA5);
        check("t4_data1", log_data[1], 8'h3C);
        check("t4_overflow", overflow, 1);
        check("t4_word_count", word_count, 2);
`ifdef BNN_PACK_POPCOUNT_EN
        check("t4_ones", ones_count, 8);
`else
        check("t4_ones", ones_count, 0);
`endif

        // Reset after five accepted bits discards the partial word.
        clear_log();
        do_start();
        send_bits(32'h0000_001F, 5, 0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("t5_no_write", log_data.size(), 0);
        check("t5_word_count", word_count, 0);
        check("t5_overflow", overflow, 0);
        do_start();
        send(1'b1, 1'b1);
        wait_done(5);
        check("t5_data_one", log_data[0], 8'h01);
        check("t5_addr_zero", log_addr[0], 0);
        check("t5_word_count_one", word_count, 1);
        clear_log();
        do_start();
        send(1'b0, 1'b1);
        wait_done(6);
        check("t5_data_zero", log_data[0], 8'h00);

        // act_valid in IDLE is ignored; start during PACK is ignored.
        clear_log();
        act_valid = 1'b1; act_bit = 1'b1; act_last = 1'b1;
        repeat (3) tick();
        act_valid = 1'b0; act_bit = 1'b0; act_last = 1'b0;
        repeat (2) tick();
        check("t6_idle_writes", log_data.size(), 0);
        check("t6_idle_done", done_cnt, 6);
        do_start();
        send_bits(32'h0000_0005, 3, 0);
        do_start();
        send_bits(32'h0000_001E, 5, 1);
        wait_done(7);
        check("t6_writes", log_data.size(), 1);
        check("t6_data0", log_data[0], 8'hF5);
        check("t6_word_count", word_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
